// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder and its CLA slice.
package nibble_add_pkg;

  // Width of one processing slice.
  localparam int NIB_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibbles needed to cover an operand of the given width.
  function automatic int calc_num_nib(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-look-ahead adder slice.
module cla4_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] gen_s;
  logic [NIB_W-1:0] prop_s;
  logic [NIB_W:0]   carry_s;

  // Generate/propagate terms and flattened look-ahead carries.
  always_comb begin
    gen_s      = a & b;
    prop_s     = a ^ b;
    carry_s[0] = cin;
    carry_s[1] = gen_s[0] | (prop_s[0] & cin);
    carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0])
               | (prop_s[1] & prop_s[0] & cin);
    carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1])
               | (prop_s[2] & prop_s[1] & gen_s[0])
               | (prop_s[2] & prop_s[1] & prop_s[0] & cin);
    carry_s[4] = gen_s[3] | (prop_s[3] & gen_s[2])
               | (prop_s[3] & prop_s[2] & gen_s[1])
               | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0])
               | (prop_s[3] & prop_s[2] & prop_s[1] & prop_s[0] & cin);
    s          = prop_s ^ carry_s[NIB_W-1:0];
    cout       = carry_s[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one nibble per cycle, LSB first, through a single
// CLA slice, with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NUM_NIB = calc_num_nib(WIDTH);
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  // Reject widths that cannot be split into whole nibbles.
  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state_r;
  state_t state_next_s;
  logic   accept_s;
  logic   step_s;

  logic [IDX_W-1:0]                idx_r;
  logic                            carry_r;
  logic [NUM_NIB-1:0][NIB_W-1:0]   a_r;
  logic [NUM_NIB-1:0][NIB_W-1:0]   b_r;
  logic [NUM_NIB-1:0][NIB_W-1:0]   sum_r;

  logic                            in_ready_r;
  logic                            out_valid_r;
  logic                            busy_r;

  logic [NIB_W-1:0]                nib_a_s;
  logic [NIB_W-1:0]                nib_b_s;
  logic [NIB_W-1:0]                nib_sum_s;
  logic                            nib_cout_s;

  // Next-state decode and datapath enables for the sequencer.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a_s = a_r[idx_r];
    nib_b_s = b_r[idx_r];
  end

  cla4_slice u_slice (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .s    (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Operand capture at acceptance, then one nibble of sum and carry per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else if (accept_s) begin
      a_r     <= in_a;
      b_r     <= in_b;
      carry_r <= in_cin;
      idx_r   <= '0;
    end else if (step_s) begin
      sum_r[idx_r] <= nib_sum_s;
      carry_r      <= nib_cout_s;
      if (idx_r != LAST_IDX) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Handshake and status flags registered from the next state so they
  // change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sum   = sum_r;
  assign out_cout  = carry_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16 main, WIDTH=4 boundary).
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_cin, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_ready, out_valid, out_cout, busy;
  logic [W-1:0]  out_sum;

  logic          in_valid4, in_cin4, out_ready4;
  logic [3:0]    in_a4, in_b4;
  logic          in_ready4, out_valid4, out_cout4, busy4;
  logic [3:0]    out_sum4;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the 16-bit DUT completes an output handshake.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got sum %0h cout %0b, expected no result", out_sum, out_cout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", 32'(out_sum), 32'(mon_e.sum));
        chk("cout", 32'(out_cout), 32'(mon_e.cout));
      end
    end
  end

  // Present a pair, hold until accepted, optionally push the hand-computed result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit push, input logic [W-1:0] es, input logic ec);
    bit   ok;
    exp_t e;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got in_ready %0b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.sum  = es;
      e.cout = ec;
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
  endtask

  // Wait (bounded) for the scoreboard to empty, then realign to posedge+1.
  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 transaction with its single-cycle latency checked inline.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] es, input logic ec);
    in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 32'(in_ready4), 32'd1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    in_a4 = ~a; in_b4 = ~b; in_cin4 = ~cin;
    @(negedge clk);
    chk("w4_valid_early", 32'(out_valid4), 32'd0);
    @(negedge clk);
    chk("w4_valid", 32'(out_valid4), 32'd1);
    chk("w4_sum", 32'(out_sum4), 32'(es));
    chk("w4_cout", 32'(out_cout4), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] va [8] = '{16'h0004, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000, 16'h7FFF};
  logic [W-1:0] vb [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h8000, 16'h00F1, 16'h1234, 16'h0000, 16'h0000};
  logic         vc [8] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
  logic [W-1:0] vs [8] = '{16'h0007, 16'h0000, 16'hFFFF, 16'h0000, 16'h1000, 16'hBE01, 16'h0001, 16'h8000};
  logic         vo [8] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_a4 = 4'h0; in_b4 = 4'h0; in_cin4 = 1'b0; out_ready4 = 1'b1;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // First vector with exact latency: out_valid seen at the 5th negedge after acceptance.
    send(va[0], vb[0], vc[0], 1'b1, vs[0], vo[0]);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), (i == 5) ? 32'd1 : 32'd0);
      if (i == 2) chk("run_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;

    // Remaining directed vectors, back to back.
    for (int v = 1; v < 8; v++) send(va[v], vb[v], vc[v], 1'b1, vs[v], vo[v]);
    drain();

    // Backpressure: result held stable, second pair waits for the out handshake.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'h5555);
      chk("bp_cout", 32'(out_cout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0);
    drain();

    // Reset two cycles into RUN: no result, state and registers cleared.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_sum", 32'(out_sum), 32'd0);
    chk("abort_cout", 32'(out_cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_sum", 32'(out_sum), 32'd0);
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE01, 1'b0);
    drain();

    // WIDTH=4 boundary cases.
    send4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    send4(4'h9, 4'h9, 1'b0, 4'h2, 1'b1);
    send4(4'h7, 4'h8, 1'b0, 4'hF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
